gpio_pad_bank: RTL and testbench
================================

GPIO_PAD_BANK -- requirements
Module: gpio_pad_bank

Interface
REQ-001 SHALL have parameter NUM_PINS, default 11: number of GPIO channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (2..4).
REQ-003 SHALL have parameter DEBOUNCE_W, default 8: debounce counter and threshold width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  single clock domain, all flops rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 pad_in_i  in  NUM_PINS  raw pad levels, asynchronous to clk.
REQ-007 dir_i  in  NUM_PINS  per-pin direction, 1 = output, 0 = input.
REQ-008 out_val_i  in  NUM_PINS  value to drive on output pins.
REQ-009 edge_mode_i  in  2*NUM_PINS  per-pin irq mode, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
REQ-010 debounce_i  in  DEBOUNCE_W  debounce threshold in clk cycles, shared by all pins.
REQ-011 irq_clr_i  in  NUM_PINS  per-pin write-1-to-clear of irq_status_o.
REQ-012 pad_out_o  out  NUM_PINS  registered pad output value.
REQ-013 pad_oe_o  out  NUM_PINS  registered pad output enable, 1 = drive.
REQ-014 in_val_o  out  NUM_PINS  synchronised, debounced input level.
REQ-015 irq_status_o  out  NUM_PINS  sticky per-pin edge flags.
REQ-016 irq_o  out  1  OR-reduction of irq_status_o.

Function
REQ-017 pad_out_o[i] SHALL be out_val_i[i] and pad_oe_o[i] SHALL be dir_i[i], both registered, with 1 cycle latency.
REQ-018 Each pad_in_i bit SHALL pass through SYNC_STAGES flops; the last stage is sync[i].
REQ-019 Each pin SHALL hold a stable register (in_val_o[i]) and a DEBOUNCE_W-bit counter cnt[i].
REQ-020 If sync[i] == stable[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-021 If sync[i] != stable[i] and cnt[i] + 1 >= debounce_i, stable[i] SHALL take sync[i] and cnt[i] SHALL clear on the same edge; otherwise cnt[i] SHALL increment.
REQ-022 stable[i] SHALL therefore update after exactly max(debounce_i,1) consecutive differing cycles; debounce_i = 0 and 1 SHALL behave identically (no filtering).
REQ-023 A glitch shorter than debounce_i cycles SHALL clear cnt[i] and SHALL NOT change stable[i].
REQ-024 cnt[i] SHALL never wrap, because it clears at threshold.
REQ-025 If debounce_i is lowered mid-count to at or below cnt[i] + 1, the update SHALL occur on the next edge.
REQ-026 With debounce_i = 0, a pad change SHALL appear on in_val_o exactly SYNC_STAGES + 1 cycles after the first sampling edge.
REQ-027 An edge event SHALL be the stable[i] update edge: rising is 0->1, falling is 1->0.
REQ-028 irq_status_o[i] SHALL set on the same edge that updates stable[i] when the event matches edge_mode_i for that pin.
REQ-029 Edge events SHALL be ignored for pins with dir_i[i] = 1; in_val_o SHALL still track the pad (loopback).
REQ-030 irq_status_o[i] SHALL stay set until irq_clr_i[i] = 1 is sampled; clear SHALL take effect on the next edge.
REQ-031 If set and clear coincide on a pin, set SHALL win and the flag SHALL remain 1.
REQ-032 Changing edge_mode_i SHALL NOT alter already-set flags.
REQ-033 irq_o SHALL be combinational from the irq_status_o flops, with no extra latency.

Reset
REQ-034 When rst_n = 0, the following SHALL be 0 immediately, independent of clk: all synchroniser flops, stable, cnt, pad_out_o, pad_oe_o (all pins input), irq_status_o, and irq_o.
REQ-035 After reset release with pad_in_i[i] = 1, a rising event SHALL be generated normally once debounce completes; software masks this with edge_mode_i = 00 until configured.
REQ-036 Reset asserted mid-debounce SHALL discard the count, with no partial-update artefact after release.

Verification
REQ-037 Scenario 1: dir_i = 0x7FF, out_val_i = 0x155 -> the next cycle gives pad_out_o = 0x155 and pad_oe_o = 0x7FF.
REQ-038 Scenario 2: SYNC_STAGES = 2, debounce_i = 0, pin 4 mode 01, pad_in_i[4] rises -> in_val_o[4] = 1 and irq_status_o[4] = 1 at cycle 3, and irq_o = 1.
REQ-039 Scenario 3: debounce_i = 10, pin 7 pulses high for 9 cycles -> no in_val_o change and no irq; a high pulse of 10 cycles -> in_val_o[7] = 1 after 2 + 10 cycles.
REQ-040 Scenario 4: mode 11 on pin 0, pad toggles 0->1->0 with a flag pending, then irq_clr_i[0] = 1 on the same cycle as the falling update -> flag stays 1; clearing one cycle later -> 0.
REQ-041 Scenario 5: pin 8 with dir_i = 1 and mode 11, pad_in_i toggled -> in_val_o[8] follows and irq_status_o[8] stays 0.
REQ-042 Scenario 6: rst_n asserted with cnt[2] = 5 of 10 -> all outputs are 0 asynchronously; after release, pin 2 needs a full 10 cycles to update.

Source files
------------

// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: registered output/enable path, per-pin input synchroniser,
// debounce filter and sticky edge-interrupt flags with OR-reduced irq.
module gpio_pad_bank #(
  parameter int NUM_PINS    = 11,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PINS-1:0]     pad_in_i,
  input  logic [NUM_PINS-1:0]     dir_i,
  input  logic [NUM_PINS-1:0]     out_val_i,
  input  logic [2*NUM_PINS-1:0]   edge_mode_i,
  input  logic [DEBOUNCE_W-1:0]   debounce_i,
  input  logic [NUM_PINS-1:0]     irq_clr_i,
  output logic [NUM_PINS-1:0]     pad_out_o,
  output logic [NUM_PINS-1:0]     pad_oe_o,
  output logic [NUM_PINS-1:0]     in_val_o,
  output logic [NUM_PINS-1:0]     irq_status_o,
  output logic                    irq_o
);

  logic [NUM_PINS-1:0]   sync_p0 [SYNC_STAGES];
  logic [NUM_PINS-1:0]   stable_p1;
  logic [NUM_PINS-1:0]   stable_d;
  logic [NUM_PINS-1:0]   irq_p1;
  logic [NUM_PINS-1:0]   irq_set;
  logic [DEBOUNCE_W-1:0] cnt_p1 [NUM_PINS];
  logic [DEBOUNCE_W-1:0] cnt_d  [NUM_PINS];
  logic [NUM_PINS-1:0]   sync_last;

  // One extra bit keeps cnt+1 from overflowing; a threshold of 0 always hits.
  function automatic logic thresh_hit(input logic [DEBOUNCE_W-1:0] cnt,
                                      input logic [DEBOUNCE_W-1:0] thr);
    logic [DEBOUNCE_W:0] nxt;
    nxt = {1'b0, cnt} + (DEBOUNCE_W+1)'(1);
    return nxt >= {1'b0, thr};
  endfunction

  assign sync_last = sync_p0[SYNC_STAGES-1];

  // Output path: one register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_out_o <= '0;
      pad_oe_o  <= '0;
    end else begin
      pad_out_o <= out_val_i;
      pad_oe_o  <= dir_i;
    end
  end

  // Stage p0: synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
    end else begin
      sync_p0[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  // Stage p1: debounce decision and edge detection
  always_comb begin
    stable_d = stable_p1;
    irq_set  = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != stable_p1[i]) begin
        if (thresh_hit(cnt_p1[i], debounce_i)) begin
          stable_d[i] = sync_last[i];
          irq_set[i]  = !dir_i[i] &&
                        (sync_last[i] ? edge_mode_i[2*i] : edge_mode_i[2*i+1]);
        end else begin
          cnt_d[i] = cnt_p1[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p1 <= '0;
      irq_p1    <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt_p1[i] <= '0;
    end else begin
      stable_p1 <= stable_d;
      irq_p1    <= (irq_p1 & ~irq_clr_i) | irq_set;
      for (int i = 0; i < NUM_PINS; i++) cnt_p1[i] <= cnt_d[i];
    end
  end

  assign in_val_o     = stable_p1;
  assign irq_status_o = irq_p1;
  assign irq_o        = |irq_p1;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Bench for gpio_pad_bank: vector table for the output path, directed corner
// sequences, and randomized traffic against a run-length behavioural model.
module tb_gpio_pad_bank;
  localparam int N  = 11;
  localparam int SS = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  pad_in_i, dir_i, out_val_i, irq_clr_i;
  logic [2*N-1:0] edge_mode_i;
  logic [DW-1:0] debounce_i;
  logic [N-1:0]  pad_out_o, pad_oe_o, in_val_o, irq_status_o;
  logic          irq_o;

  gpio_pad_bank #(.NUM_PINS(N), .SYNC_STAGES(SS), .DEBOUNCE_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .pad_in_i(pad_in_i), .dir_i(dir_i),
    .out_val_i(out_val_i), .edge_mode_i(edge_mode_i), .debounce_i(debounce_i),
    .irq_clr_i(irq_clr_i), .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o),
    .in_val_o(in_val_o), .irq_status_o(irq_status_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pad history, settled level and length of the current
  // run of cycles in which the synchronised level disagrees with it.
  bit [N-1:0] m_hist [SS];
  bit [N-1:0] m_stable, m_irq, m_out, m_oe;
  int         m_run [N];

  typedef struct {
    logic [N-1:0] dir;
    logic [N-1:0] outv;
    logic [N-1:0] exp_out;
    logic [N-1:0] exp_oe;
  } reg_vec_t;
  reg_vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SS; s++) m_hist[s] = '0;
    m_stable = '0; m_irq = '0; m_out = '0; m_oe = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic compare_all();
    chk("pad_out", 32'(pad_out_o), 32'(m_out));
    chk("pad_oe", 32'(pad_oe_o), 32'(m_oe));
    chk("in_val", 32'(in_val_o), 32'(m_stable));
    chk("irq_status", 32'(irq_status_o), 32'(m_irq));
    chk("irq_o", 32'(irq_o), 32'(|m_irq));
  endtask

  task automatic step();
    bit [N-1:0] nstable, set;
    int thr;
    if (!rst_n) begin
      model_clear();
    end else begin
      thr = (debounce_i == 0) ? 1 : int'(debounce_i);
      nstable = m_stable;
      set = '0;
      for (int i = 0; i < N; i++) begin
        if (m_hist[SS-1][i] != m_stable[i]) begin
          if (m_run[i] + 1 >= thr) begin
            nstable[i] = m_hist[SS-1][i];
            m_run[i] = 0;
            if (!dir_i[i]) begin
              if (nstable[i] && edge_mode_i[2*i]) set[i] = 1'b1;
              if (!nstable[i] && edge_mode_i[2*i+1]) set[i] = 1'b1;
            end
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_irq = (m_irq & ~irq_clr_i) | set;
      m_stable = nstable;
      for (int s = SS-1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = pad_in_i;
      m_out = out_val_i;
      m_oe = dir_i;
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst pad_out", 32'(pad_out_o), 32'h0);
    chk("rst pad_oe", 32'(pad_oe_o), 32'h0);
    chk("rst in_val", 32'(in_val_o), 32'h0);
    chk("rst irq_status", 32'(irq_status_o), 32'h0);
    chk("rst irq_o", 32'(irq_o), 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    pad_in_i = '0; dir_i = '0; out_val_i = '0; irq_clr_i = '0;
    edge_mode_i = '0; debounce_i = '0;
    #1 rst_n = 1'b0;
    #2;
    model_clear();
    compare_all();
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;

    // Output register path
    vecs[0] = '{dir: 11'h7FF, outv: 11'h155, exp_out: 11'h155, exp_oe: 11'h7FF};
    vecs[1] = '{dir: 11'h000, outv: 11'h2AA, exp_out: 11'h2AA, exp_oe: 11'h000};
    vecs[2] = '{dir: 11'h0F0, outv: 11'h7FF, exp_out: 11'h7FF, exp_oe: 11'h0F0};
    vecs[3] = '{dir: 11'h000, outv: 11'h000, exp_out: 11'h000, exp_oe: 11'h000};
    for (int v = 0; v < 4; v++) begin
      dir_i = vecs[v].dir; out_val_i = vecs[v].outv;
      step();
      chk("vec pad_out", 32'(pad_out_o), 32'(vecs[v].exp_out));
      chk("vec pad_oe", 32'(pad_oe_o), 32'(vecs[v].exp_oe));
    end

    // Pin 4 rising, no debounce: visible after SYNC_STAGES+1 edges
    debounce_i = 0;
    edge_mode_i[8 +: 2] = 2'b01;
    pad_in_i[4] = 1'b1;
    steps(2);
    chk("s2 in_val4 early", 32'(in_val_o[4]), 32'h0);
    step();
    chk("s2 in_val4", 32'(in_val_o[4]), 32'h1);
    chk("s2 irq4", 32'(irq_status_o[4]), 32'h1);
    chk("s2 irq_o", 32'(irq_o), 32'h1);
    irq_clr_i[4] = 1'b1; step(); irq_clr_i = '0;
    chk("s2 clr", 32'(irq_status_o[4]), 32'h0);

    // Pin 7: 9-cycle glitch rejected, 10-cycle pulse accepted
    debounce_i = 10;
    edge_mode_i[14 +: 2] = 2'b11;
    pad_in_i[7] = 1'b1; steps(9);
    pad_in_i[7] = 1'b0; steps(12);
    chk("s3 glitch in_val7", 32'(in_val_o[7]), 32'h0);
    chk("s3 glitch irq7", 32'(irq_status_o[7]), 32'h0);
    pad_in_i[7] = 1'b1; steps(10);
    pad_in_i[7] = 1'b0; step();
    chk("s3 in_val7 at 11", 32'(in_val_o[7]), 32'h0);
    step();
    chk("s3 in_val7 at 12", 32'(in_val_o[7]), 32'h1);
    steps(14);
    irq_clr_i[7] = 1'b1; step(); irq_clr_i = '0;

    // Pin 0 both edges: coincident set/clear keeps the flag
    debounce_i = 0;
    edge_mode_i[0 +: 2] = 2'b11;
    pad_in_i[0] = 1'b1; steps(3);
    chk("s4 rise flag", 32'(irq_status_o[0]), 32'h1);
    pad_in_i[0] = 1'b0; steps(2);
    irq_clr_i[0] = 1'b1; step();
    chk("s4 set wins", 32'(irq_status_o[0]), 32'h1);
    step(); irq_clr_i = '0;
    chk("s4 cleared", 32'(irq_status_o[0]), 32'h0);

    // Pin 8 as output: loopback tracks, no interrupt
    dir_i[8] = 1'b1;
    edge_mode_i[16 +: 2] = 2'b11;
    pad_in_i[8] = 1'b1; steps(3);
    chk("s5 in_val8 hi", 32'(in_val_o[8]), 32'h1);
    chk("s5 irq8", 32'(irq_status_o[8]), 32'h0);
    pad_in_i[8] = 1'b0; steps(3);
    chk("s5 in_val8 lo", 32'(in_val_o[8]), 32'h0);
    chk("s5 irq8 after fall", 32'(irq_status_o[8]), 32'h0);
    dir_i[8] = 1'b0;

    // Pin 2: reset mid-count discards the partial count
    debounce_i = 10;
    pad_in_i[2] = 1'b1; steps(7);
    async_reset();
    steps(11);
    chk("s6 in_val2 at 11", 32'(in_val_o[2]), 32'h0);
    step();
    chk("s6 in_val2 at 12", 32'(in_val_o[2]), 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) begin
        debounce_i = DW'($urandom_range(0, 4));
        dir_i = N'($urandom) & N'($urandom);
        edge_mode_i = (2*N)'($urandom);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) pad_in_i[i] = ~pad_in_i[i];
      irq_clr_i = N'($urandom) & N'($urandom) & N'($urandom);
      out_val_i = N'($urandom);
      if ($urandom_range(0, 40) == 0) debounce_i = DW'($urandom_range(0, 4));
      if (c == 333) async_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
